// File: rtl/pc_pkg.sv
// Shared program-counter opcode encoding, used by pc_sequencer and instruction decode.
package pc_pkg;

  localparam logic [3:0] PC_OP_SEL = 4'h7;

  localparam logic [3:0] OP_JMP   = 4'h0;
  localparam logic [3:0] OP_JMPC  = 4'h1;
  localparam logic [3:0] OP_JMPZ  = 4'h2;
  localparam logic [3:0] OP_JMPR  = 4'h3;
  localparam logic [3:0] OP_JMPCR = 4'h4;
  localparam logic [3:0] OP_JMPZR = 4'h5;
  localparam logic [3:0] OP_JMPNZ = 4'h6;
  localparam logic [3:0] OP_JMPNC = 4'h7;
  localparam logic [3:0] OP_CALL  = 4'h8;
  localparam logic [3:0] OP_RET   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hA;
  localparam logic [3:0] OP_NOP_B = 4'hB;
  localparam logic [3:0] OP_NOP_C = 4'hC;
  localparam logic [3:0] OP_NOP_D = 4'hD;
  localparam logic [3:0] OP_NOP_E = 4'hE;
  localparam logic [3:0] OP_NOP_F = 4'hF;

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address LIFO: flop array with combinational top-of-stack read.
// The write pointer wraps modulo depth while the level counter saturates.
module pc_return_stack #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8,
  parameter int LVL_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [ADDR_W-1:0] mem_d [STACK_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_m1;
  logic [LVL_W-1:0]  level_q, level_d;

  assign ptr_m1 = ptr_q - PTR_W'(1);
  assign top    = mem_q[ptr_m1];
  assign level  = level_q;
  assign full   = (level_q == LVL_MAX);
  assign empty  = (level_q == '0);

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    level_d = level_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (!full) level_d = level_q + LVL_W'(1);
    end else if (pop) begin
      ptr_d = ptr_m1;
      if (!empty) level_d = level_q - LVL_W'(1);
    end
  end

  // Storage is deliberately left uninitialised by reset; only the bookkeeping clears.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      ptr_q   <= '0;
      level_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: jumps, CALL/RET via pc_return_stack, HALT and stall.
// Define PC_STACK_GUARD_EN to block stack over/underflow and report it on stack_err.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              ADDR_W      = 16,
  parameter int              STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [15:0]                    opcode,
  input  logic [ADDR_W-1:0]              operand,
  input  logic [3:0]                     flags,
  output logic [ADDR_W-1:0]              pc,
  output logic                           halted,
  output logic [$clog2(STACK_DEPTH):0]   stack_level,
  output logic                           stack_err
);

  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] pc_inc, pc_rel, stack_top;
  logic              push, pop, stack_full, stack_empty;
  logic              flag_c, flag_z, is_pc_op;
  logic [3:0]        pc_op;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign pc_rel   = pc_q + operand;
  assign flag_c   = flags[1];
  assign flag_z   = flags[0];
  assign is_pc_op = (opcode[15:12] == PC_OP_SEL);
  assign pc_op    = opcode[11:8];

  pc_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .LVL_W       (LVL_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stack_top),
    .level     (stack_level),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // Next-pc decision; stall and halt freeze pc and stack alike.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    err_d    = err_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (!stall && !halted_q) begin
      pc_d = pc_inc;
      if (is_pc_op) begin
        case (pc_op)
          OP_JMP:   pc_d = operand;
          OP_JMPC:  pc_d = flag_c  ? operand : pc_inc;
          OP_JMPZ:  pc_d = flag_z  ? operand : pc_inc;
          OP_JMPR:  pc_d = pc_rel;
          OP_JMPCR: pc_d = flag_c  ? pc_rel  : pc_inc;
          OP_JMPZR: pc_d = flag_z  ? pc_rel  : pc_inc;
          OP_JMPNZ: pc_d = !flag_z ? operand : pc_inc;
          OP_JMPNC: pc_d = !flag_c ? operand : pc_inc;
          OP_CALL: begin
`ifdef PC_STACK_GUARD_EN
            if (stack_full) begin
              err_d = 1'b1;
            end else begin
              push = 1'b1;
              pc_d = operand;
            end
`else
            push = 1'b1;
            pc_d = operand;
`endif
          end
          OP_RET: begin
`ifdef PC_STACK_GUARD_EN
            if (stack_empty) begin
              err_d = 1'b1;
            end else begin
              pop  = 1'b1;
              pc_d = stack_top;
            end
`else
            pop  = 1'b1;
            pc_d = stack_top;
`endif
          end
          OP_HALT: begin
            pc_d     = pc_q;
            halted_d = 1'b1;
          end
          default: pc_d = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign pc     = pc_q;
  assign halted = halted_q;
`ifdef PC_STACK_GUARD_EN
  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

endmodule
